// File: rtl/dac_config_seq.sv
// dac_config_seq: shifts a DAC register table out over 3-wire SPI once the DAC is ready, then serves runtime single-word writes
module dac_config_seq #(
  parameter int NUM_REGS = 8,
  parameter int SCLK_DIV = 4,
  parameter int CS_GAP = 8,
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk12Mhz,
  input  logic          RESET,
  input  logic          dac_ready,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          wr_req,
  input  logic [15:0]   wr_data,
  output logic          wr_ack,
  output logic          busy,
  output logic          config_done,
  output logic          spi_cs_n,
  output logic          spi_sclk,
  output logic          spi_mosi
);
  localparam int PW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
  localparam int GW = CS_GAP > 1 ? $clog2(CS_GAP) : 1;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, SHIFT = 3'd3, GAP = 3'd4, READY = 3'd5;
  logic [2:0] st, st_n;
  logic [AW-1:0] addr_n;
  logic [15:0] sr, sr_n;
  logic [5:0] h, h_n;
  logic [PW-1:0] ph, ph_n;
  logic [GW-1:0] gc, gc_n;
  logic done_n, ack_n, ph_end, gap_end, last;
  assign ph_end = ph == PW'(SCLK_DIV - 1);
  assign gap_end = gc == GW'(CS_GAP - 1);
  assign last = rom_addr == AW'(NUM_REGS - 1);
  always_comb begin
    st_n = st;
    addr_n = rom_addr;
    sr_n = sr;
    h_n = h;
    ph_n = ph;
    gc_n = gc;
    done_n = config_done;
    ack_n = 1'b0;
    if (st != IDLE && !dac_ready) begin
      st_n = IDLE;
      addr_n = '0;
      done_n = 1'b0;
    end else begin
      case (st)
        IDLE: st_n = dac_ready ? FETCH : IDLE;
        FETCH: st_n = LOAD;
        LOAD: begin
          sr_n = rom_data;
          h_n = '0;
          ph_n = '0;
          st_n = SHIFT;
        end
        SHIFT: begin
          ph_n = ph_end ? '0 : ph + 1'b1;
          if (ph_end) begin
            h_n = h + 6'd1;
            sr_n = h[0] ? {sr[14:0], 1'b0} : sr;
            gc_n = '0;
            st_n = h == 6'd32 ? GAP : SHIFT;
          end
        end
        GAP: begin
          gc_n = gc + 1'b1;
          if (gap_end) begin
            st_n = last ? READY : FETCH;
            done_n = config_done | last;
            addr_n = last ? rom_addr : rom_addr + 1'b1;
          end
        end
        READY: if (wr_req) begin
          sr_n = wr_data;
          ack_n = 1'b1;
          h_n = '0;
          ph_n = '0;
          st_n = SHIFT;
        end
        default: st_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk12Mhz) begin
    if (RESET) begin
      st <= IDLE;
      rom_addr <= '0;
      sr <= '0;
      h <= '0;
      ph <= '0;
      gc <= '0;
      config_done <= 1'b0;
      wr_ack <= 1'b0;
      busy <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      st <= st_n;
      rom_addr <= addr_n;
      sr <= sr_n;
      h <= h_n;
      ph <= ph_n;
      gc <= gc_n;
      config_done <= done_n;
      wr_ack <= ack_n;
      busy <= st_n != IDLE && st_n != READY;
      spi_cs_n <= st_n != SHIFT;
      spi_sclk <= st_n == SHIFT && h_n[0];
      spi_mosi <= st_n == SHIFT && sr_n[15];
    end
  end
endmodule
